// File: rtl/instr_seq.sv
// instr_seq: multi-cycle RV32I sequencer owning pc/instr and memory/regfile handshakes.
// Optional feature: define RV_ILLEGAL_TRAP_EN to trap on illegal encodings instead of executing them as NOP.
module instr_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    input  logic [6:0]  cmd_op,
    input  logic [31:0] immI,
    input  logic [31:0] immB,
    input  logic [31:0] immJ,
    input  logic [31:0] rs1_data,
    input  logic        br_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] pc
`ifdef RV_ILLEGAL_TRAP_EN
    ,
    output logic        trap
`endif
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        BOOT, FETCH, DECODE, EXEC, MEM, WB
`ifdef RV_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc_plus4;
    logic        imem_req_q, dmem_req_q, dmem_we_q, rf_we_q;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic        legal;
    logic [6:0]  ir_op;

    assign pc_plus4  = pc_q + 32'd4;
    assign ir_op     = instr_q[6:0];
    assign legal     = (instr_q[1:0] == 2'b11) && (cmd_op inside {OP_LOAD, OP_STORE, OP_OP, OP_OPIMM,
                       OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_FENCE, OP_SYSTEM});
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign imem_req  = imem_req_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign rf_we     = rf_we_q;
    assign wb_sel    = wb_sel_q;

    // Next state, pc and instruction register; pc only moves when an instruction retires.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            BOOT:   state_d = FETCH;
            FETCH:  if (imem_ack) begin
                        instr_d = imem_rdata;
                        state_d = DECODE;
                    end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (!legal) begin
`ifdef RV_ILLEGAL_TRAP_EN
                    state_d = TRAP;
`else
                    pc_d    = pc_plus4;
                    state_d = FETCH;
`endif
                end else if (cmd_op == OP_LOAD || cmd_op == OP_STORE) begin
                    state_d = MEM;
                end else if (cmd_op == OP_BRANCH) begin
                    pc_d    = br_taken ? pc_q + immB : pc_plus4;
                    state_d = FETCH;
                end else if (cmd_op == OP_FENCE || cmd_op == OP_SYSTEM) begin
                    pc_d    = pc_plus4;
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: if (dmem_ack) begin
                     if (ir_op == OP_STORE) begin
                         pc_d    = pc_plus4;
                         state_d = FETCH;
                     end else begin
                         state_d = WB;
                     end
                 end
            WB: begin
                pc_d    = (ir_op == OP_JAL)  ? pc_q + immJ :
                          (ir_op == OP_JALR) ? (rs1_data + immI) & 32'hFFFF_FFFE : pc_plus4;
                state_d = FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    // Writeback source for the state being entered; zero everywhere but WB.
    always_comb begin
        wb_sel_d = 2'd0;
        if (state_d == WB)
            wb_sel_d = (instr_d[6:0] == OP_LUI)  ? 2'd3 :
                       (instr_d[6:0] == OP_JAL || instr_d[6:0] == OP_JALR) ? 2'd2 :
                       (instr_d[6:0] == OP_LOAD) ? 2'd1 : 2'd0;
    end

    // State, architectural registers and Moore outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0013;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            wb_sel_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            imem_req_q <= state_d == FETCH;
            dmem_req_q <= state_d == MEM;
            dmem_we_q  <= (state_d == MEM) && (instr_d[6:0] == OP_STORE);
            rf_we_q    <= state_d == WB;
            wb_sel_q   <= wb_sel_d;
        end
    end

`ifdef RV_ILLEGAL_TRAP_EN
    logic trap_q;
    assign trap = trap_q;

    // Sticky illegal-instruction flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trap_q <= 1'b0;
        else        trap_q <= state_d == TRAP;
    end
`endif
endmodule
